// File: rtl/hack_pkg.sv
// Shared types and sizes for the ROM boot loader.
// Holds the loader state encoding, the program-store geometry and small
// state-classification helpers.
package hack_pkg;

  localparam int unsigned ROM_DEPTH   = 4096;
  localparam int unsigned HACK_WORD_W = 16;
  localparam int unsigned HACK_ADDR_W = 15;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned PTR_W       = 12;
  localparam int unsigned COUNT_W     = 13;
  localparam int unsigned LEN_W       = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    WRITE   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } boot_state_e;

  // States in which the loader takes a byte from the stream.
  function automatic logic takes_byte(boot_state_e s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) || (s == DATA_LO);
  endfunction

  // States that belong to an in-flight load.
  function automatic logic is_loading(boot_state_e s);
    return takes_byte(s) || (s == WRITE);
  endfunction

endpackage

// File: rtl/rom_boot_loader_byte_pair_assembler.sv
// byte_pair_assembler: joins a high byte and a low byte into one 16-bit word.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   byte_in      stream byte
//   take_hi      capture byte_in as the high byte
//   take_lo      capture byte_in as the low byte and complete the word
//   word         registered completed word
//   word_c       combinational {high byte, byte_in}, valid while take_lo is high
//   word_valid   one-cycle pulse the cycle after a word completes
module byte_pair_assembler
  import hack_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BYTE_W-1:0]      byte_in,
  input  logic                   take_hi,
  input  logic                   take_lo,
  output logic [HACK_WORD_W-1:0] word,
  output logic [HACK_WORD_W-1:0] word_c,
  output logic                   word_valid
);

  logic [BYTE_W-1:0] hi_byte;

  // The completed value is visible in the accepting cycle so the loader can
  // act on the length field without an extra cycle.
  assign word_c = {hi_byte, byte_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_byte    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= take_lo;
      if (take_hi) hi_byte <= byte_in;
      if (take_lo) word    <= word_c;
    end
  end

endmodule

// File: rtl/rom_boot_loader.sv
// rom_boot_loader: loads the 4K x 16 program store from a byte stream.
// Stream: 16-bit big-endian length N, then N words high byte first.
// Holds the CPU in reset while loading and owns the ROM address port.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start                 one-cycle pulse, begins a load from IDLE/DONE/ERROR
//   in_data, in_valid     stream byte and its valid
//   in_ready              loader accepts a byte this cycle
//   cpu_pc                CPU instruction address
//   rom_address           pointer while busy, cpu_pc otherwise
//   rom_wdata, rom_we     assembled word and one-cycle write strobe
//   cpu_reset             CPU reset hold
//   busy, done, error     load status
//   word_count            words written in the current or last load
module rom_boot_loader
  import hack_pkg::*;
#(
  parameter int unsigned DEPTH     = ROM_DEPTH,
  parameter int unsigned ADDR_W    = HACK_ADDR_W,
  parameter int unsigned DATA_W    = HACK_WORD_W,
  parameter bit          BOOT_HOLD = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BYTE_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  cpu_pc,
  output logic [ADDR_W-1:0]  rom_address,
  output logic [DATA_W-1:0]  rom_wdata,
  output logic               rom_we,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [COUNT_W-1:0] word_count
);

  boot_state_e        state_q, state_d;
  logic [PTR_W-1:0]   pointer_q, pointer_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic in_ready_q, in_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic error_q, error_d;
  logic cpu_reset_q, cpu_reset_d;
  logic we_q, we_d;

  logic                   accept;
  logic                   take_hi, take_lo;
  logic [HACK_WORD_W-1:0] word;
  logic [HACK_WORD_W-1:0] word_c;
  logic                   word_valid;

  assign accept = in_valid && in_ready_q;

  byte_pair_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (in_data),
    .take_hi    (take_hi),
    .take_lo    (take_lo),
    .word       (word),
    .word_c     (word_c),
    .word_valid (word_valid)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pointer_q   <= '0;
      length_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= BOOT_HOLD;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pointer_q   <= pointer_d;
      length_q    <= length_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_reset_q <= cpu_reset_d;
      we_q        <= we_d;
    end
  end

  // Next state, datapath updates and output decode of the next state.
  always_comb begin
    state_d   = state_q;
    pointer_d = pointer_q;
    length_d  = length_q;
    count_d   = count_q;
    take_hi   = 1'b0;
    take_lo   = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d   = LEN_HI;
          pointer_d = '0;
          count_d   = '0;
        end
      end
      LEN_HI: begin
        if (accept) begin
          take_hi = 1'b1;
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          take_lo  = 1'b1;
          length_d = word_c;
          if (word_c == '0)               state_d = DONE;
          else if (word_c > LEN_W'(DEPTH)) state_d = ERROR;
          else                            state_d = DATA_HI;
        end
      end
      DATA_HI: begin
        if (accept) begin
          take_hi = 1'b1;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept) begin
          take_lo = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        count_d = COUNT_W'(count_q + 1'b1);
        // Last word stops before the pointer would wrap at DEPTH.
        if (LEN_W'(pointer_q) == LEN_W'(length_q - 1'b1)) begin
          state_d = DONE;
        end else begin
          pointer_d = PTR_W'(pointer_q + 1'b1);
          state_d   = DATA_HI;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = takes_byte(state_d);
    busy_d     = is_loading(state_d);
    done_d     = (state_d == DONE);
    error_d    = (state_d == ERROR);
    we_d       = (state_d == WRITE);
    if (state_d == IDLE)      cpu_reset_d = BOOT_HOLD;
    else if (state_d == DONE) cpu_reset_d = 1'b0;
    else                      cpu_reset_d = 1'b1;
  end

  // Address mux: loader pointer while loading, CPU PC otherwise.
  assign rom_address = busy_q ? ADDR_W'(pointer_q) : cpu_pc;
  assign rom_wdata   = DATA_W'(word);
  assign rom_we      = we_q && word_valid;
  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign cpu_reset   = cpu_reset_q;
  assign word_count  = count_q;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Bench for rom_boot_loader: directed table of loads, hand-written corner
// sequences (gapped stream, ignored start, mid-load reset) and random loads
// checked against a list-of-words model of the program store.
`timescale 1ns/1ps
module tb_rom_boot_loader;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [15:0] word_q_t[$];

  typedef struct {
    logic [15:0] len;
    int          nw;
    logic [15:0] w[3];
    int          gap;
    bit          exp_done;
    bit          exp_err;
    int          exp_count;
  } vec_t;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] cpu_pc;
  logic [14:0] rom_address;
  logic [15:0] rom_wdata;
  logic        rom_we;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [12:0] word_count;

  int   vec_count  = 0;
  int   miss_count = 0;
  int   cyc        = 0;
  wr_t  wr_log[$];
  logic [15:0] rom_model [4096];

  rom_boot_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cpu_pc      (cpu_pc),
    .rom_address (rom_address),
    .rom_wdata   (rom_wdata),
    .rom_we      (rom_we),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .word_count  (word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ROM-side observer: log every write and keep a copy of the store.
  always @(negedge clk) begin
    if (!reset && rom_we) begin
      wr_log.push_back('{addr: rom_address, data: rom_wdata, cyc: cyc});
      rom_model[rom_address[11:0]] = rom_wdata;
      check("we_only_while_busy", 32'(busy), 32'd1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model: outcome of a load depends only on the length field.
  function automatic void model(input int len, output bit d, output bit e, output int cnt);
    if (len > 4096) begin d = 1'b0; e = 1'b1; cnt = 0; end
    else            begin d = 1'b1; e = 1'b0; cnt = len; end
  endfunction

  function automatic vec_t mk(input logic [15:0] len, input int nw,
                              input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input int gap,
                              input bit d, input bit e, input int cnt);
    vec_t v;
    v.len = len; v.nw = nw; v.w[0] = a; v.w[1] = b; v.w[2] = c;
    v.gap = gap; v.exp_done = d; v.exp_err = e; v.exp_count = cnt;
    return v;
  endfunction

  // Called at a negedge; returns at a negedge with in_valid low.
  task automatic send_bytes(input byte_q_t bytes, input int gap);
    for (int i = 0; i < bytes.size(); i++) begin
      int waited;
      if (gap > 0 && i > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = bytes[i];
      waited   = 0;
      while (!in_ready && waited < 50) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        check("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input logic [15:0] len, input word_q_t words, input int gap,
                          input bit exp_done, input bit exp_err, input int exp_count);
    byte_q_t bytes;
    int      n;
    wr_log.delete();
    cpu_pc = 15'($urandom);
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_clears_error", 32'(error), 32'd0);
    check("start_clears_done", 32'(done), 32'd0);
    check("start_cpu_reset", 32'(cpu_reset), 32'd1);
    check("start_count", 32'(word_count), 32'd0);
    bytes.push_back(len[15:8]);
    bytes.push_back(len[7:0]);
    foreach (words[i]) begin
      bytes.push_back(words[i][15:8]);
      bytes.push_back(words[i][7:0]);
    end
    send_bytes(bytes, gap);
    wait_idle();
    check("final_done", 32'(done), 32'(exp_done));
    check("final_error", 32'(error), 32'(exp_err));
    check("final_cpu_reset", 32'(cpu_reset), exp_err ? 32'd1 : 32'd0);
    check("final_count", 32'(word_count), 32'(exp_count));
    check("write_total", 32'(wr_log.size()), 32'(exp_count));
    n = (wr_log.size() < exp_count) ? wr_log.size() : exp_count;
    for (int i = 0; i < n; i++) begin
      check("write_addr", 32'(wr_log[i].addr), 32'(i));
      check("write_data", 32'(wr_log[i].data), 32'(words[i]));
      if (gap == 0 && i > 0)
        check("write_spacing", 32'(wr_log[i].cyc - wr_log[i-1].cyc), 32'd3);
    end
    if (exp_done) begin
      for (int i = 0; i < n && i < 4; i++) begin
        cpu_pc = 15'(i);
        #1;
        check("readback_addr", 32'(rom_address), 32'(i));
        check("readback_data", 32'(rom_model[i]), 32'(words[i]));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    vec_t    tbl[5];
    word_q_t wq;
    byte_q_t bq;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; cpu_pc = 15'h0005;
    repeat (3) @(negedge clk);
    start = 1'b1;                   // start during reset must be ignored
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_rom_we", 32'(rom_we), 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    check("rst_rom_wdata", 32'(rom_wdata), 32'd0);
    check("rst_addr_passthru", 32'(rom_address), 32'h0005);

    // Directed table: {length, words, gap, expected done/error/count}.
    tbl[0] = mk(16'd3,    3, 16'hABCD, 16'h1234, 16'hFF00, 0, 1'b1, 1'b0, 3);
    tbl[1] = mk(16'd0,    0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b1, 1'b0, 0);
    tbl[2] = mk(16'h1001, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 1'b1, 0);
    tbl[3] = mk(16'd1,    1, 16'hBEEF, 16'h0000, 16'h0000, 1, 1'b1, 1'b0, 1);
    tbl[4] = mk(16'd2,    2, 16'h0000, 16'hFFFF, 16'h0000, 3, 1'b1, 1'b0, 2);
    for (int t = 0; t < 5; t++) begin
      wq.delete();
      for (int i = 0; i < tbl[t].nw; i++) wq.push_back(tbl[t].w[i]);
      run_load(tbl[t].len, wq, tbl[t].gap, tbl[t].exp_done, tbl[t].exp_err, tbl[t].exp_count);
    end

    // Gapped stream with a start pulse mid-load.
    wr_log.delete();
    pulse_start();
    bq.delete();
    bq.push_back(8'h00); bq.push_back(8'h02); bq.push_back(8'hAB);
    send_bytes(bq, 5);
    repeat (5) @(negedge clk);
    check("gap_no_early_write", 32'(wr_log.size()), 32'd0);
    pulse_start();
    check("gap_start_ignored_busy", 32'(busy), 32'd1);
    check("gap_start_ignored_ready", 32'(in_ready), 32'd1);
    bq.delete();
    bq.push_back(8'hCD); bq.push_back(8'h11); bq.push_back(8'h22);
    send_bytes(bq, 5);
    wait_idle();
    check("gap_done", 32'(done), 32'd1);
    check("gap_count", 32'(word_count), 32'd2);
    check("gap_writes", 32'(wr_log.size()), 32'd2);
    if (wr_log.size() == 2) begin
      check("gap_w0_addr", 32'(wr_log[0].addr), 32'd0);
      check("gap_w0_data", 32'(wr_log[0].data), 32'hABCD);
      check("gap_w1_addr", 32'(wr_log[1].addr), 32'd1);
      check("gap_w1_data", 32'(wr_log[1].data), 32'h1122);
    end

    // Reset after the first data byte abandons the load.
    wr_log.delete();
    pulse_start();
    bq.delete();
    bq.push_back(8'h00); bq.push_back(8'h04); bq.push_back(8'hAA);
    send_bytes(bq, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_count", 32'(word_count), 32'd0);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (8) @(negedge clk);
    in_valid = 1'b0;
    check("mid_rst_no_write", 32'(wr_log.size()), 32'd0);
    wq.delete();
    wq.push_back(16'h0F0F); wq.push_back(16'hF00D);
    run_load(16'd2, wq, 0, 1'b1, 1'b0, 2);

    // Random loads against the model.
    for (int r = 0; r < 10; r++) begin
      int  sel, len, gap, cnt;
      bit  d, e;
      sel = $urandom_range(0, 9);
      if (sel == 0)      len = 0;
      else if (sel == 1) len = $urandom_range(4097, 65535);
      else               len = $urandom_range(1, 40);
      gap = $urandom_range(0, 2);
      model(len, d, e, cnt);
      wq.delete();
      for (int i = 0; i < cnt; i++) wq.push_back(16'($urandom));
      run_load(16'(len), wq, gap, d, e, cnt);
    end

    // Full-depth load: addresses 0..4095, no wrap.
    wq.delete();
    for (int i = 0; i < 4096; i++) wq.push_back(16'($urandom));
    run_load(16'd4096, wq, 0, 1'b1, 1'b0, 4096);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
